// File: rtl/monster_pkg.sv
// Shared types, widths and default tuning constants for the monster director.
package monster_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIFF_W  = 11;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned TMO_W   = 8;
    localparam int unsigned RAND_W  = 20;
    localparam int unsigned KILL_W  = 8;

    localparam logic [ACC_W-1:0] COOLDOWN_MIN_DEFAULT  = 16'd400;
    localparam logic [TMO_W-1:0] SPAWN_TIMEOUT_DEFAULT = 8'd16;

    typedef enum logic [1:0] {
        COOLDOWN,
        SPAWN,
        ALIVE,
        KILLED
    } director_state_t;

    // Accumulate a frame's scroll distance, clamping at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W+1)'(b);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/monster_director_if.sv
// Spawn/kill handshake and monster status between the director and the monster block.
interface monster_director_if;
    import monster_pkg::*;

    logic               gene;
    logic               hit;
    logic               beat_mons;
    logic               monster_active;
    logic [COORD_W-1:0] monster_x;
    logic [COORD_W-1:0] monster_y;
    logic [COORD_W-1:0] monster_size_x;
    logic [COORD_W-1:0] monster_size_y;

    modport master (
        output gene, hit, beat_mons,
        input  monster_active, monster_x, monster_y, monster_size_x, monster_size_y
    );

    modport slave (
        input  gene, hit, beat_mons,
        output monster_active, monster_x, monster_y, monster_size_x, monster_size_y
    );

endinterface

// File: rtl/box_overlap.sv
// Combinational check that two centres lie within given half-extent limits on both axes.
module box_overlap
    import monster_pkg::*;
(
    input  logic [COORD_W-1:0] i_ax,
    input  logic [COORD_W-1:0] i_ay,
    input  logic [COORD_W-1:0] i_bx,
    input  logic [COORD_W-1:0] i_by,
    input  logic [DIFF_W-1:0]  i_lim_x,
    input  logic [DIFF_W-1:0]  i_lim_y,
    output logic               o_overlap_c
);

    logic [DIFF_W-1:0] w_dx;
    logic [DIFF_W-1:0] w_dy;
    logic [DIFF_W-1:0] w_adx;
    logic [DIFF_W-1:0] w_ady;

    // One extra bit keeps the signed difference of two 10-bit coordinates exact.
    assign w_dx  = DIFF_W'(i_ax) - DIFF_W'(i_bx);
    assign w_dy  = DIFF_W'(i_ay) - DIFF_W'(i_by);
    assign w_adx = w_dx[DIFF_W-1] ? DIFF_W'(-w_dx) : w_dx;
    assign w_ady = w_dy[DIFF_W-1] ? DIFF_W'(-w_dy) : w_dy;

    assign o_overlap_c = (w_adx <= i_lim_x) && (w_ady <= i_lim_y);

endmodule

// File: rtl/monster_director.sv
// Decides when to spawn a monster and resolves bullet/doodle collisions while it lives.
module monster_director
    import monster_pkg::*;
#(
    parameter logic [ACC_W-1:0] COOLDOWN_MIN  = COOLDOWN_MIN_DEFAULT,
    parameter logic [TMO_W-1:0] SPAWN_TIMEOUT = SPAWN_TIMEOUT_DEFAULT
)(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [COORD_W-1:0] distance,
    input  logic [RAND_W-1:0]  random_num,
    monster_director_if.master mon,
    input  logic [COORD_W-1:0] doodle_x,
    input  logic [COORD_W-1:0] doodle_y,
    input  logic [COORD_W-1:0] doodle_size,
    input  logic               doodle_falling,
    input  logic               bullet_active,
    input  logic [COORD_W-1:0] bullet_x,
    input  logic [COORD_W-1:0] bullet_y,
    output logic               doodle_dead,
    output logic [KILL_W-1:0]  kill_count
);

    director_state_t   r_state;
    director_state_t   w_next;
    logic              r_frame_d;
    logic              r_fe;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_thr;
    logic              r_seed;
    logic [TMO_W-1:0]  r_cnt;
    logic [TMO_W-1:0]  w_cnt_inc;
    logic              r_gene;
    logic              r_hit;
    logic              r_beat;
    logic              r_dead;
    logic [KILL_W-1:0] r_kills;

    logic              w_bullet_box;
    logic              w_body_box;
    logic              w_stomp;
    logic              w_alive;
    logic              w_hit_c;
    logic              w_beat_c;
    logic              w_dead_c;
    logic              w_enter_cd;
    logic              w_unused_rnd;

    assign w_unused_rnd = ^random_num[RAND_W-1:8];

    // Bullet is a point, so its limits are the monster half-extents alone.
    box_overlap u_bullet_box (
        .i_ax        (bullet_x),
        .i_ay        (bullet_y),
        .i_bx        (mon.monster_x),
        .i_by        (mon.monster_y),
        .i_lim_x     (DIFF_W'(mon.monster_size_x)),
        .i_lim_y     (DIFF_W'(mon.monster_size_y)),
        .o_overlap_c (w_bullet_box)
    );

    box_overlap u_body_box (
        .i_ax        (doodle_x),
        .i_ay        (doodle_y),
        .i_bx        (mon.monster_x),
        .i_by        (mon.monster_y),
        .i_lim_x     (DIFF_W'(mon.monster_size_x) + DIFF_W'(doodle_size)),
        .i_lim_y     (DIFF_W'(mon.monster_size_y) + DIFF_W'(doodle_size)),
        .o_overlap_c (w_body_box)
    );

    // Stomp beats bullet, bullet beats side contact; nothing is evaluated outside ALIVE.
    assign w_alive    = (r_state == ALIVE);
    assign w_stomp    = w_body_box && doodle_falling && (doodle_y < mon.monster_y);
    assign w_beat_c   = w_alive && w_stomp;
    assign w_hit_c    = w_alive && !w_stomp && bullet_active && w_bullet_box;
    assign w_dead_c   = w_alive && !w_stomp && !(bullet_active && w_bullet_box) && w_body_box;
    assign w_cnt_inc  = r_cnt + TMO_W'(1);
    assign w_enter_cd = (w_next == COOLDOWN) && (r_state != COOLDOWN);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= COOLDOWN;
        else       r_state <= w_next;
    end

    // Next-state selection for the spawn/kill lifecycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            COOLDOWN: if (r_acc >= r_thr) w_next = SPAWN;
            SPAWN: begin
                if (mon.monster_active)              w_next = ALIVE;
                else if (w_cnt_inc == SPAWN_TIMEOUT) w_next = COOLDOWN;
            end
            ALIVE: begin
                if (w_hit_c || w_beat_c)     w_next = KILLED;
                else if (!mon.monster_active) w_next = COOLDOWN;
            end
            KILLED: if (!mon.monster_active) w_next = COOLDOWN;
            default: w_next = COOLDOWN;
        endcase
    end

    // Frame-edge detect, scroll accumulator, spawn threshold and spawn timeout counter.
    // r_seed makes the first cooldown after Reset draw its random threshold like any later one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_d <= 1'b0;
            r_fe      <= 1'b0;
            r_acc     <= '0;
            r_thr     <= COOLDOWN_MIN;
            r_seed    <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_frame_d <= frame_clk;
            r_fe      <= frame_clk & ~r_frame_d;
            r_cnt     <= (r_state == SPAWN) ? w_cnt_inc : '0;
            if (w_enter_cd) begin
                r_acc  <= '0;
                r_thr  <= COOLDOWN_MIN + ACC_W'(random_num[7:0]);
                r_seed <= 1'b0;
            end else if (r_state == COOLDOWN) begin
                if (r_seed) begin
                    r_thr  <= COOLDOWN_MIN + ACC_W'(random_num[7:0]);
                    r_seed <= 1'b0;
                end
                if (r_fe) r_acc <= sat_add(r_acc, distance);
            end
        end
    end

    // Registered spawn request, kill pulses, sticky death flag and kill counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gene  <= 1'b0;
            r_hit   <= 1'b0;
            r_beat  <= 1'b0;
            r_dead  <= 1'b0;
            r_kills <= '0;
        end else begin
            r_gene <= (r_state == SPAWN);
            r_hit  <= w_hit_c;
            r_beat <= w_beat_c;
            if (w_dead_c)             r_dead  <= 1'b1;
            if (w_hit_c || w_beat_c)  r_kills <= r_kills + KILL_W'(1);
        end
    end

    assign mon.gene      = r_gene;
    assign mon.hit       = r_hit;
    assign mon.beat_mons = r_beat;
    assign doodle_dead   = r_dead;
    assign kill_count    = r_kills;

endmodule

// File: tb/tb_monster_director.sv
// Scoreboarded random bench for monster_director.
module tb_monster_director;

    typedef enum int {EV_GENE, EV_HIT, EV_BEAT, EV_DEAD} ev_kind_t;
    typedef struct { ev_kind_t kind; int frames; } ev_t;
    typedef struct {
        int mx; int my; int msx; int msy;
        int dx; int dy; int ds; int bx; int by;
        bit fall; bit ba;
    } scen_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] distance = '0;
    logic [19:0] random_num = '0;
    logic [9:0] doodle_x = '0;
    logic [9:0] doodle_y = '0;
    logic [9:0] doodle_size = '0;
    logic       doodle_falling = 1'b0;
    logic       bullet_active = 1'b0;
    logic [9:0] bullet_x = '0;
    logic [9:0] bullet_y = '0;
    logic       doodle_dead;
    logic [7:0] kill_count;

    monster_director_if mon_if();

    monster_director dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .distance       (distance),
        .random_num     (random_num),
        .mon            (mon_if),
        .doodle_x       (doodle_x),
        .doodle_y       (doodle_y),
        .doodle_size    (doodle_size),
        .doodle_falling (doodle_falling),
        .bullet_active  (bullet_active),
        .bullet_x       (bullet_x),
        .bullet_y       (bullet_y),
        .doodle_dead    (doodle_dead),
        .kill_count     (kill_count)
    );

    always #5 Clk = ~Clk;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  frame_cnt = 0;
    int  exp_thr = 0;
    int  kills = 0;
    bit  dead = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int f);
        ev_t e;
        e.kind = k;
        e.frames = f;
        exp_q.push_back(e);
    endtask

    // Scoreboard side: pop and compare whenever the DUT shows an event.
    task automatic note(input ev_kind_t k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=%s@frame%0d expected=none", k.name(), frame_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_GENE && e.frames != frame_cnt)) begin
                failures++;
                $display("FAIL event actual=%s@frame%0d expected=%s@frame%0d",
                         k.name(), frame_cnt, e.kind.name(), e.frames);
            end
        end
    endtask

    initial begin : monitor
        bit gp;
        bit dp;
        gp = 1'b0;
        dp = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (mon_if.gene && !gp) note(EV_GENE);
                if (mon_if.hit)         note(EV_HIT);
                if (mon_if.beat_mons)   note(EV_BEAT);
                if (doodle_dead && !dp) note(EV_DEAD);
            end
            gp = mon_if.gene;
            dp = doodle_dead;
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference outcome: 0 none, 1 bullet kill, 2 stomp, 3 side contact.
    function automatic int classify(input scen_t s);
        bit bul;
        bit body;
        bit stomp;
        bul   = s.ba && iabs(s.bx - s.mx) <= s.msx && iabs(s.by - s.my) <= s.msy;
        body  = iabs(s.dx - s.mx) <= s.msx + s.ds && iabs(s.dy - s.my) <= s.msy + s.ds;
        stomp = body && s.fall && (s.dy < s.my);
        if (stomp) return 2;
        if (bul)   return 1;
        if (body)  return 3;
        return 0;
    endfunction

    function automatic scen_t mk(input int mx, input int my, input int msx, input int msy,
                                 input int dx, input int dy, input int ds,
                                 input int bx, input int by, input bit fall, input bit ba);
        scen_t s;
        s.mx = mx; s.my = my; s.msx = msx; s.msy = msy;
        s.dx = dx; s.dy = dy; s.ds = ds; s.bx = bx; s.by = by;
        s.fall = fall; s.ba = ba;
        return s;
    endfunction

    function automatic scen_t rand_scen();
        scen_t s;
        int rx;
        int ry;
        s.mx  = int'($urandom_range(100, 900));
        s.my  = int'($urandom_range(100, 900));
        s.msx = int'($urandom_range(4, 30));
        s.msy = int'($urandom_range(4, 30));
        s.ds  = int'($urandom_range(4, 16));
        rx = s.msx + s.ds + 10;
        ry = s.msy + s.ds + 10;
        s.dx = s.mx - rx + int'($urandom_range(0, 2 * rx));
        s.dy = s.my - ry + int'($urandom_range(0, 2 * ry));
        s.bx = s.mx - (s.msx + 6) + int'($urandom_range(0, 2 * (s.msx + 6)));
        s.by = s.my - (s.msy + 6) + int'($urandom_range(0, 2 * (s.msy + 6)));
        s.fall = ($urandom_range(0, 1) == 1);
        s.ba   = ($urandom_range(0, 1) == 1);
        return s;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 20'hFFFFF));
    endfunction

    // Frames until spawn follow from ceil(threshold / distance).
    task automatic run_cooldown(input int d);
        int n;
        n = (exp_thr + d - 1) / d;
        expect_ev(EV_GENE, n);
        distance = 10'(d);
        frame_cnt = 0;
        while (!mon_if.gene && frame_cnt <= n + 3) begin
            frame_cnt++;
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            for (int i = 0; i < 7 && !mon_if.gene; i++) @(negedge Clk);
        end
        check("gene_seen", int'(mon_if.gene), 1);
    endtask

    task automatic run_timeout(input int rn_next);
        int cnt;
        random_num = 20'(rn_next);
        exp_thr = 400 + (rn_next % 256);
        cnt = 1;
        while (mon_if.gene && cnt < 40) begin
            @(negedge Clk);
            if (mon_if.gene) cnt++;
        end
        check("spawn_hold_cycles", cnt, 16);
        repeat (2) @(negedge Clk);
    endtask

    task automatic run_alive(input scen_t s, input int rn_next);
        int code;
        int n;
        mon_if.monster_x      = 10'(s.mx);
        mon_if.monster_y      = 10'(s.my);
        mon_if.monster_size_x = 10'(s.msx);
        mon_if.monster_size_y = 10'(s.msy);
        mon_if.monster_active = 1'b1;
        n = 0;
        while (mon_if.gene && n < 8) begin
            @(negedge Clk);
            n++;
        end
        check("gene_drop", int'(mon_if.gene), 0);
        code = classify(s);
        if (code == 2) begin
            expect_ev(EV_BEAT, 0);
            kills++;
        end else if (code == 1) begin
            expect_ev(EV_HIT, 0);
            kills++;
        end else if (code == 3 && !dead) begin
            expect_ev(EV_DEAD, 0);
            dead = 1'b1;
        end
        doodle_x       = 10'(s.dx);
        doodle_y       = 10'(s.dy);
        doodle_size    = 10'(s.ds);
        doodle_falling = s.fall;
        bullet_x       = 10'(s.bx);
        bullet_y       = 10'(s.by);
        bullet_active  = s.ba;
        repeat (6) @(negedge Clk);
        bullet_active  = 1'b0;
        doodle_falling = 1'b0;
        doodle_x       = '0;
        doodle_y       = '0;
        random_num     = 20'(rn_next);
        exp_thr        = 400 + (rn_next % 256);
        mon_if.monster_active = 1'b0;
        repeat (4) @(negedge Clk);
        check("kill_count", int'(kill_count), kills % 256);
        check("doodle_dead", int'(doodle_dead), int'(dead));
    endtask

    initial begin : stim
        mon_if.monster_active = 1'b0;
        mon_if.monster_x      = '0;
        mon_if.monster_y      = '0;
        mon_if.monster_size_x = '0;
        mon_if.monster_size_y = '0;
        random_num = 20'hABC64;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset_gene", int'(mon_if.gene), 0);
        check("reset_hit", int'(mon_if.hit), 0);
        check("reset_beat", int'(mon_if.beat_mons), 0);
        check("reset_dead", int'(doodle_dead), 0);
        check("reset_kills", int'(kill_count), 0);
        Reset = 1'b0;
        exp_thr = 500;

        distance = '0;
        for (int i = 0; i < 10; i++) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            repeat (5) @(negedge Clk);
        end
        check("gene_zero_distance", int'(mon_if.gene), 0);

        run_cooldown(10);
        run_timeout(rnd());

        run_cooldown(int'($urandom_range(8, 60)));
        run_alive(mk(200, 100, 20, 11, 0, 0, 8, 215, 108, 1'b0, 1'b1), rnd());
        run_cooldown(int'($urandom_range(8, 60)));
        run_alive(mk(200, 100, 20, 11, 200, 85, 8, 200, 100, 1'b1, 1'b1), rnd());
        run_cooldown(int'($urandom_range(8, 60)));
        run_alive(mk(200, 100, 20, 11, 225, 100, 8, 0, 0, 1'b0, 1'b0), rnd());
        run_cooldown(int'($urandom_range(8, 60)));
        run_alive(mk(200, 100, 20, 11, 0, 0, 8, 300, 300, 1'b0, 1'b1), rnd());

        for (int ep = 0; ep < 20; ep++) begin
            run_cooldown(int'($urandom_range(8, 60)));
            if ($urandom_range(0, 3) == 0) run_timeout(rnd());
            else                           run_alive(rand_scen(), rnd());
        end

        run_cooldown(int'($urandom_range(8, 60)));
        Reset = 1'b1;
        @(negedge Clk);
        check("midreset_gene", int'(mon_if.gene), 0);
        check("midreset_dead", int'(doodle_dead), 0);
        check("midreset_kills", int'(kill_count), 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
